// File: rtl/pit_pkg.sv
// Shared definitions for the interval-timer counter read path: access modes and status-byte layout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pit_pkg;

    // Access-mode encodings carried in the RW field of the control word
    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_WORD  = 2'b11;

    // Bit positions inside the read-back status byte {OUT, null_count, RW, mode, BCD}
    localparam int STAT_OUT_BIT   = 7;
    localparam int STAT_NULL_BIT  = 6;
    localparam int STAT_RW_HI     = 5;
    localparam int STAT_RW_LO     = 4;
    localparam int STAT_MODE_HI   = 3;
    localparam int STAT_MODE_LO   = 1;
    localparam int STAT_BCD_BIT   = 0;

endpackage

// File: rtl/read_byte_select.sv
// Picks the byte of a 16-bit count word that the CPU sees for the current access mode.
// Latency: purely combinational.
// Backpressure: none; output follows inputs continuously.
module read_byte_select
    import pit_pkg::*;
(
    input  logic [15:0] word,
    input  logic [1:0]  rw,
    input  logic        byte_sel,
    output logic [7:0]  sel_byte
);

    // Mode decode: word mode alternates halves, unprogrammed reads return zero
    always_comb begin
        sel_byte = 8'h00;
        case (rw)
            RW_LSB:  sel_byte = word[7:0];
            RW_MSB:  sel_byte = word[15:8];
            RW_WORD: sel_byte = byte_sel ? word[15:8] : word[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/count_read_latch.sv
// Counter read path: count latch, read byte-select flip-flop, optional status latch (PIT_STATUS_READBACK_EN).
// Latency: rd at cycle N returns data_out/data_valid at cycle N+1; latch_cmd captures at edge N.
// Backpressure: none; every rd is served in order, except one coincident with counter_programmed, which is dropped.
module count_read_latch
    import pit_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] current_count,
    input  logic [1:0]  RW,
    input  logic        counter_programmed,
    input  logic        latch_cmd,
    input  logic        rd,
    input  logic [7:0]  status_in,
    input  logic        status_latch_cmd,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        latched
);

    logic [15:0] latch_reg;
    logic [15:0] latch_reg_nxt;
    logic        latched_nxt;
    logic        byte_sel;
    logic        byte_sel_nxt;
    logic [7:0]  data_out_nxt;
    logic        data_valid_nxt;
    logic [15:0] src_word;
    logic [7:0]  sel_byte;
    logic        status_read;
    logic [7:0]  status_byte;

    // A held snapshot takes precedence over the live count
    assign src_word = latched ? latch_reg : current_count;

    read_byte_select u_read_byte_select (
        .word     (src_word),
        .rw       (RW),
        .byte_sel (byte_sel),
        .sel_byte (sel_byte)
    );

`ifdef PIT_STATUS_READBACK_EN
    logic [7:0] status_reg;
    logic [7:0] status_reg_nxt;
    logic       status_held;
    logic       status_held_nxt;

    // A pending status byte pre-empts the count for exactly one read
    assign status_read = rd && status_held;
    assign status_byte = status_reg;

    // Status latch: release on reprogram or read, then re-arm against the post-read state
    always_comb begin
        status_reg_nxt  = status_reg;
        status_held_nxt = status_held;
        if (counter_programmed) begin
            status_held_nxt = 1'b0;
        end else if (status_read) begin
            status_held_nxt = 1'b0;
        end
        if (status_latch_cmd && !status_held_nxt) begin
            status_reg_nxt  = status_in;
            status_held_nxt = 1'b1;
        end
    end

    // Status latch state
    always_ff @(posedge CLK) begin
        if (RST) begin
            status_reg  <= 8'h00;
            status_held <= 1'b0;
        end else begin
            status_reg  <= status_reg_nxt;
            status_held <= status_held_nxt;
        end
    end
`else
    logic unused_status;

    // Status inputs are kept on the port list but have no effect in this build
    assign unused_status = ^{status_in, status_latch_cmd};
    assign status_read   = 1'b0;
    assign status_byte   = 8'h00;
`endif

    // Read and count-latch next state: reprogram, then read, then latch command
    always_comb begin
        latch_reg_nxt  = latch_reg;
        latched_nxt    = latched;
        byte_sel_nxt   = byte_sel;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        if (counter_programmed) begin
            latched_nxt  = 1'b0;
            byte_sel_nxt = 1'b0;
        end else if (rd) begin
            data_valid_nxt = 1'b1;
            if (status_read) begin
                data_out_nxt = status_byte;
            end else begin
                data_out_nxt = sel_byte;
                case (RW)
                    RW_LSB, RW_MSB: latched_nxt = 1'b0;
                    RW_WORD: begin
                        byte_sel_nxt = ~byte_sel;
                        if (byte_sel) begin
                            latched_nxt = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (latch_cmd && !latched_nxt) begin
            latch_reg_nxt = current_count;
            latched_nxt   = 1'b1;
        end
    end

    // Read-path state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            latch_reg  <= 16'h0000;
            latched    <= 1'b0;
            byte_sel   <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
        end else begin
            latch_reg  <= latch_reg_nxt;
            latched    <= latched_nxt;
            byte_sel   <= byte_sel_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
        end
    end

endmodule

// File: tb/tb_count_read_latch.sv
// Directed bench for count_read_latch: word/byte modes, latch hold, reprogram and reset mid-word.
// Latency: checks each read one cycle after its strobe.
// Backpressure: none; bench drives on the falling edge and samples there.
module tb_count_read_latch;

    logic        CLK;
    logic        RST;
    logic [15:0] current_count;
    logic [1:0]  RW;
    logic        counter_programmed;
    logic        latch_cmd;
    logic        rd;
    logic [7:0]  status_in;
    logic        status_latch_cmd;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        latched;

    int tests_run;
    int tests_failed;

    count_read_latch dut (
        .CLK                (CLK),
        .RST                (RST),
        .current_count      (current_count),
        .RW                 (RW),
        .counter_programmed (counter_programmed),
        .latch_cmd          (latch_cmd),
        .rd                 (rd),
        .status_in          (status_in),
        .status_latch_cmd   (status_latch_cmd),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .latched            (latched)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // One read strobe; outputs are checked at the next falling edge
    task automatic do_rd(input string tag, input logic [7:0] exp);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
        chk({tag, "_dat"}, {8'd0, data_out}, {8'd0, exp});
    endtask

    task automatic do_latch(input logic [15:0] cnt);
        current_count = cnt;
        latch_cmd     = 1'b1;
        step();
        latch_cmd     = 1'b0;
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        RST                = 1'b1;
        current_count      = 16'h0000;
        RW                 = 2'b11;
        counter_programmed = 1'b0;
        latch_cmd          = 1'b0;
        rd                 = 1'b0;
        status_in          = 8'h00;
        status_latch_cmd   = 1'b0;
        step();
        step();
        chk("rst_dout", {8'd0, data_out}, 16'h0000);
        chk("rst_dv", {15'd0, data_valid}, 16'd0);
        chk("rst_latched", {15'd0, latched}, 16'd0);
        RST = 1'b0;
        step();

        // Unlatched word read, back-to-back strobes
        current_count = 16'h1234;
        do_rd("word_lsb", 8'h34);
        do_rd("word_msb", 8'h12);
        step();
        chk("word_dv_drop", {15'd0, data_valid}, 16'd0);
        chk("word_hold", {8'd0, data_out}, 16'h0012);

        // Latched word read survives a count change
        do_latch(16'hABCD);
        current_count = 16'h0001;
        chk("lat_set", {15'd0, latched}, 16'd1);
        do_rd("lat_lsb", 8'hCD);
        chk("lat_mid", {15'd0, latched}, 16'd1);
        do_rd("lat_msb", 8'hAB);
        chk("lat_clr", {15'd0, latched}, 16'd0);

        // Second latch command is ignored while a snapshot is held
        do_latch(16'h0500);
        do_latch(16'h0400);
        do_rd("rep_lsb", 8'h00);
        do_rd("rep_msb", 8'h05);
        chk("rep_clr", {15'd0, latched}, 16'd0);

        // MSB-only: read releases the latch and a coincident latch_cmd re-latches
        RW = 2'b10;
        do_latch(16'h9876);
        current_count = 16'h4321;
        latch_cmd = 1'b1;
        do_rd("msb_rd", 8'h98);
        latch_cmd = 1'b0;
        chk("msb_relatch", {15'd0, latched}, 16'd1);
        current_count = 16'h0000;
        do_rd("msb_rd2", 8'h43);
        chk("msb_clr", {15'd0, latched}, 16'd0);

        // LSB-only live read
        RW = 2'b01;
        current_count = 16'h5AA5;
        do_rd("lsb_rd", 8'hA5);

        // Unprogrammed mode returns zero and leaves the latch alone
        do_latch(16'h7777);
        RW = 2'b00;
        do_rd("rw0_rd", 8'h00);
        chk("rw0_keep", {15'd0, latched}, 16'd1);
        RW = 2'b01;
        do_rd("rw0_after", 8'h77);
        chk("rw0_clr", {15'd0, latched}, 16'd0);

        // Reprogram mid word drops a coincident read and restarts at LSB
        RW = 2'b11;
        current_count = 16'hBEEF;
        do_rd("rp_lsb", 8'hEF);
        counter_programmed = 1'b1;
        rd = 1'b1;
        step();
        counter_programmed = 1'b0;
        rd = 1'b0;
        chk("rp_drop_dv", {15'd0, data_valid}, 16'd0);
        chk("rp_drop_hold", {8'd0, data_out}, 16'h00EF);
        do_rd("rp_lsb2", 8'hEF);
        do_rd("rp_msb2", 8'hBE);

        // Reprogram clears a held snapshot
        do_latch(16'h2468);
        counter_programmed = 1'b1;
        step();
        counter_programmed = 1'b0;
        chk("rp_unlatch", {15'd0, latched}, 16'd0);

        // Reset mid word discards the partial read
        current_count = 16'hCAFE;
        do_rd("rst_lsb", 8'hFE);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_mid_dout", {8'd0, data_out}, 16'h0000);
        do_rd("rst_lsb2", 8'hFE);
        do_rd("rst_msb2", 8'hCA);

`ifdef PIT_STATUS_READBACK_EN
        // Status byte is returned first, then the latched count
        status_in = 8'hB6;
        status_latch_cmd = 1'b1;
        do_latch(16'h0102);
        status_latch_cmd = 1'b0;
        status_in = 8'h00;
        current_count = 16'hFFFF;
        do_rd("st_status", 8'hB6);
        chk("st_keep", {15'd0, latched}, 16'd1);
        do_rd("st_lsb", 8'h02);
        do_rd("st_msb", 8'h01);
        chk("st_clr", {15'd0, latched}, 16'd0);
`else
        // Without read-back the status command has no effect on reads
        status_in = 8'hB6;
        status_latch_cmd = 1'b1;
        current_count = 16'h0102;
        step();
        status_latch_cmd = 1'b0;
        do_rd("nost_lsb", 8'h02);
        do_rd("nost_msb", 8'h01);
        chk("nost_latched", {15'd0, latched}, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
